// File: rtl/cont_pkg.sv
// Shared constants for the modulus up/down counter family.
// CONT_WRAP / CONT_SAT select the end-of-range behaviour at each instantiation site.
package cont_pkg;
  localparam bit CONT_WRAP = 1'b0;
  localparam bit CONT_SAT  = 1'b1;
endpackage

// File: rtl/cont_mod_updown.sv
// Loadable up/down counter over [0, mod_max] with wrap-or-saturate ends,
// a registered wrap pulse and a sticky saturation flag.
module cont_mod_updown
  import cont_pkg::*;
#(
  parameter int W   = 8,
  parameter bit SAT = CONT_WRAP
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         enable,
  input  logic         up,
  input  logic [W-1:0] d,
  input  logic [W-1:0] mod_max,
  output logic [W-1:0] q,
  output logic         max_tick,
  output logic         min_tick,
  output logic         wrap_tick,
  output logic         sat_flag
);

  localparam logic [W-1:0] ONE  = W'(1);
  localparam logic [W-1:0] ZERO = '0;

  logic [W-1:0] cnt_q, cnt_d;
  logic         wrap_q, wrap_d;
  logic         sat_q, sat_d;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    sat_d  = sat_q;
    if (load) begin
      cnt_d = d;
      sat_d = 1'b0;
    end else if (enable) begin
      if (up) begin
        // Unsigned >= so an out-of-range count leaves the range on the next up step.
        if (cnt_q < mod_max) begin
          cnt_d = cnt_q + ONE;
        end else if (SAT == CONT_SAT) begin
          sat_d = 1'b1;
        end else begin
          cnt_d  = ZERO;
          wrap_d = 1'b1;
        end
      end else begin
        if (cnt_q != ZERO) begin
          cnt_d = cnt_q - ONE;
        end else if (SAT == CONT_SAT) begin
          sat_d = 1'b1;
        end else begin
          cnt_d  = mod_max;
          wrap_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= ZERO;
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      sat_q  <= sat_d;
    end
  end

  assign q         = cnt_q;
  assign wrap_tick = wrap_q;
  assign sat_flag  = sat_q;
  assign max_tick  = (cnt_q == mod_max);
  assign min_tick  = (cnt_q == ZERO);

endmodule

// File: tb/tb_cont_mod_updown.sv
// Scoreboard bench for cont_mod_updown: a wrap instance and a saturate instance
// share stimulus; each cycle's expectation targets one of them.
module tb_cont_mod_updown;
  import cont_pkg::*;

  logic       clk = 1'b0;
  logic       rst, load, enable, up;
  logic [7:0] d, mod_max;

  logic [7:0] q_w, q_s;
  logic       mx_w, mn_w, wt_w, st_w;
  logic       mx_s, mn_s, wt_s, st_s;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit         sel;
    logic [7:0] q;
    bit         w;
    bit         s;
    logic [7:0] mm;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  cont_mod_updown #(.W(8), .SAT(CONT_WRAP)) u_wrap (
    .clk(clk), .rst(rst), .load(load), .enable(enable), .up(up), .d(d),
    .mod_max(mod_max), .q(q_w), .max_tick(mx_w), .min_tick(mn_w),
    .wrap_tick(wt_w), .sat_flag(st_w)
  );

  cont_mod_updown #(.W(8), .SAT(CONT_SAT)) u_sat (
    .clk(clk), .rst(rst), .load(load), .enable(enable), .up(up), .d(d),
    .mod_max(mod_max), .q(q_s), .max_tick(mx_s), .min_tick(mn_s),
    .wrap_tick(wt_s), .sat_flag(st_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected outcome, then compare after the edge.
  task automatic cyc(input string tag, input bit sel, input bit r, input bit ld,
                     input bit en, input bit u, input logic [7:0] dv,
                     input logic [7:0] mm, input logic [7:0] eq,
                     input bit ew, input bit es);
    exp_t e;
    rst = r; load = ld; enable = en; up = u; d = dv; mod_max = mm;
    sb.push_back('{sel, eq, ew, es, mm});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (!e.sel) begin
      chk({tag, ".q"},    q_w,  e.q);
      chk({tag, ".wrap"}, wt_w, e.w);
      chk({tag, ".sat"},  st_w, e.s);
      chk({tag, ".max"},  mx_w, e.q == e.mm);
      chk({tag, ".min"},  mn_w, e.q == 8'd0);
    end else begin
      chk({tag, ".q"},    q_s,  e.q);
      chk({tag, ".wrap"}, wt_s, e.w);
      chk({tag, ".sat"},  st_s, e.s);
      chk({tag, ".max"},  mx_s, e.q == e.mm);
      chk({tag, ".min"},  mn_s, e.q == 8'd0);
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b1; enable = 1'b1; up = 1'b1; d = 8'h55; mod_max = 8'd9;
    #2;

    // Reset dominates load and enable.
    cyc("rst0", 0, 1, 1, 1, 1, 8'h55, 8'd9, 8'd0, 0, 0);
    cyc("rst1", 0, 1, 1, 1, 1, 8'h55, 8'd9, 8'd0, 0, 0);
    chk("rst.sat_q", q_s, 8'd0);
    chk("rst.sat_flag", st_s, 1'b0);
    chk("rst.sat_min", mn_s, 1'b1);

    cyc("load2a", 0, 0, 1, 0, 1, 8'h2A, 8'd9, 8'h2A, 0, 0);

    // Up wrap over [0,9].
    cyc("ld0", 0, 0, 1, 0, 1, 8'd0, 8'd9, 8'd0, 0, 0);
    for (int i = 0; i < 11; i++) begin
      logic [7:0] eq;
      eq = 8'((i + 1) % 10);
      cyc("upwrap", 0, 0, 0, 1, 1, 8'd0, 8'd9, eq, eq == 8'd0, 0);
    end

    // Down wrap from 1, then hold drops the pulse.
    cyc("ld1", 0, 0, 1, 0, 0, 8'd1, 8'd9, 8'd1, 0, 0);
    cyc("dn0", 0, 0, 0, 1, 0, 8'd0, 8'd9, 8'd0, 0, 0);
    cyc("dn9", 0, 0, 0, 1, 0, 8'd0, 8'd9, 8'd9, 1, 0);
    cyc("dn8", 0, 0, 0, 1, 0, 8'd0, 8'd9, 8'd8, 0, 0);
    cyc("hold", 0, 0, 0, 0, 0, 8'd0, 8'd9, 8'd8, 0, 0);

    // max_tick follows mod_max with no clock edge.
    mod_max = 8'd8; #1;
    chk("maxcomb.hi", mx_w, 1'b1);
    mod_max = 8'd9; #1;
    chk("maxcomb.lo", mx_w, 1'b0);

    // Saturating instance, mod_max = 5.
    cyc("sld4", 1, 0, 1, 0, 1, 8'd4, 8'd5, 8'd4, 0, 0);
    cyc("sup1", 1, 0, 0, 1, 1, 8'd0, 8'd5, 8'd5, 0, 0);
    cyc("sup2", 1, 0, 0, 1, 1, 8'd0, 8'd5, 8'd5, 0, 1);
    cyc("sup3", 1, 0, 0, 1, 1, 8'd0, 8'd5, 8'd5, 0, 1);
    cyc("shold", 1, 0, 0, 0, 1, 8'd0, 8'd5, 8'd5, 0, 1);
    cyc("sld2", 1, 0, 1, 0, 1, 8'd2, 8'd5, 8'd2, 0, 0);
    cyc("sld0", 1, 0, 1, 0, 0, 8'd0, 8'd5, 8'd0, 0, 0);
    cyc("sdn0", 1, 0, 0, 1, 0, 8'd0, 8'd5, 8'd0, 0, 1);

    // Out-of-range count on the wrapping instance.
    cyc("ld20", 0, 0, 1, 0, 1, 8'd20, 8'd9, 8'd20, 0, 0);
    cyc("oor_up", 0, 0, 0, 1, 1, 8'd0, 8'd9, 8'd0, 1, 0);
    cyc("ld20b", 0, 0, 1, 0, 0, 8'd20, 8'd9, 8'd20, 0, 0);
    cyc("oor_dn", 0, 0, 0, 1, 0, 8'd0, 8'd9, 8'd19, 0, 0);

    // Zero modulus: every enabled cycle wraps, either direction.
    cyc("mz_up0", 0, 0, 0, 1, 1, 8'd0, 8'd0, 8'd0, 1, 0);
    cyc("mz_up1", 0, 0, 0, 1, 1, 8'd0, 8'd0, 8'd0, 1, 0);
    cyc("mz_dn0", 0, 0, 0, 1, 0, 8'd0, 8'd0, 8'd0, 1, 0);
    cyc("mz_dn1", 0, 0, 0, 1, 0, 8'd0, 8'd0, 8'd0, 1, 0);

    // Load beats enable; reset mid-count clears everything.
    cyc("ld_en", 0, 0, 1, 1, 1, 8'd7, 8'd9, 8'd7, 0, 0);
    cyc("ld5", 0, 0, 1, 0, 1, 8'd5, 8'd9, 8'd5, 0, 0);
    cyc("up6", 0, 0, 0, 1, 1, 8'd0, 8'd9, 8'd6, 0, 0);
    cyc("rstmid", 0, 1, 1, 1, 1, 8'd3, 8'd9, 8'd0, 0, 0);
    chk("rstmid.sat_q", q_s, 8'd0);
    chk("rstmid.sat_flag", st_s, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cont_mod_updown.md
# cont_mod_updown

Parametrised successor to the basic loadable up-counter. Adds runtime-programmable modulus, up/down direction, wrap-or-saturate mode, a registered wrap pulse and a sticky saturation flag. Used in the UART path as the baud/oversample tick divider and bit/sample counter, and anywhere else a bounded bidirectional count is needed.

## Interface
- `W`, 8, counter and modulus width in bits (W ≥ 2).
- `SAT`, 0, end-of-range mode: 0 = wrap, 1 = saturate (hold at the bound).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load`  in  1  load `d` into the count; does not depend on `enable`.
- `enable`  in  1  advance the count by one step in the selected direction.
- `up`  in  1  direction: 1 = increment, 0 = decrement; sampled only when stepping.
- `d`  in  W  load value.
- `mod_max`  in  W  inclusive upper bound of the count range [0, mod_max]; may change at any time.
- `q`  out  W  current count (registered).
- `max_tick`  out  1  combinational, `q == mod_max`.
- `min_tick`  out  1  combinational, `q == 0`.
- `wrap_tick`  out  1  registered one-cycle pulse when a step wrapped; always 0 when SAT = 1.
- `sat_flag`  out  1  registered sticky flag: a step was blocked at a bound (SAT = 1 only).

## Operation
- Priority per edge: `rst` > `load` > `enable` step > hold.
- `rst`: q = 0, wrap_tick = 0, sat_flag = 0.
- `load`: q = d, taken as-is even if d > mod_max. wrap_tick = 0; sat_flag cleared.
- Up step (`enable` & `up`):
  - If q < mod_max: q = q + 1.
  - If q ≥ mod_max and SAT = 0: q = 0 and wrap_tick = 1 next cycle.
  - If q ≥ mod_max and SAT = 1: q holds and sat_flag is set.
- Down step (`enable` & !`up`):
  - If q > 0: q = q − 1. Applies even when q > mod_max.
  - If q = 0 and SAT = 0: q = mod_max and wrap_tick = 1.
  - If q = 0 and SAT = 1: q holds and sat_flag is set.
- No arithmetic carries out of W bits. The compare q ≥ mod_max is unsigned, so an out-of-range q on an up step wraps or holds immediately.
- mod_max = 0 with SAT = 0: q stays 0 and wrap_tick is high on every enabled cycle, in either direction.
- Hold (no `load`, no `enable`): q and sat_flag unchanged; wrap_tick = 0.

## Timing
- Step and load latency is one cycle: the new q is visible after the edge that samples the request.
- wrap_tick is high for exactly the one cycle in which q shows the wrapped value (0 or mod_max). Back-to-back wraps give wrap_tick high on consecutive cycles.
- max_tick and min_tick follow q and mod_max combinationally with zero latency. A change of mod_max updates max_tick in the same cycle.
- sat_flag rises on the edge of the blocked step and stays high until `load` or `rst`.
- `rst` asserted mid-count takes effect at the next edge regardless of `load` and `enable`; all outputs return to their reset values.

## Structure
- Shared package `cont_pkg`: constants `CONT_WRAP = 0` and `CONT_SAT = 1`, used for `SAT` at every instantiation site.
- Single flat module; no sub-module. The next-state logic is one registered block for q, wrap_tick and sat_flag, plus combinational compares for the ticks.

## Test plan
- Reset and load:
  - `rst` = 1 for 2 cycles with `enable` = 1, `load` = 1 → q = 0, wrap_tick = 0, sat_flag = 0, min_tick = 1.
  - Then `load` with d = 8'h2A and `enable` = 0 → q = 8'h2A next cycle.
- Up wrap, W = 8, SAT = 0, mod_max = 9: enable, up = 1 from q = 0 for 12 cycles → q = 0..9, 0, 1. max_tick high at q = 9. wrap_tick high only in the cycle q returns to 0.
- Down wrap, mod_max = 9, start q = 1, up = 0 for 3 steps → q = 0, 9, 8. wrap_tick high only while q = 9.
- Saturate, SAT = 1, mod_max = 5:
  - Up from q = 4 for 3 steps → q = 5, 5, 5; sat_flag set on the second step; wrap_tick never high.
  - Then `load` d = 2 → sat_flag = 0, q = 2.
- Out of range and zero modulus:
  - Load d = 20 with mod_max = 9, then up step → q = 0 and wrap_tick = 1 (SAT = 0).
  - Down step from q = 20 → q = 19.
  - mod_max = 0, enable held for 4 cycles → q = 0 and wrap_tick high for all 4 cycles.
- Simultaneous events:
  - `load` and `enable` together (d = 7) → q = 7, no step.
  - `rst` asserted mid-count at q = 6 → q = 0 next edge, all flags clear.
